// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared state encoding and sizing helpers for the fifo enqueue arbiter
package fifo_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

    // Counter must hold p_MAX_BURST itself, since it increments on the last word of a burst.
    function automatic int cnt_width(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker: first set request at or above ptr, wrapping
module rr_pick #(
    parameter int p_NUM_REQ = 4,
    parameter int p_PTR_W   = $clog2(p_NUM_REQ)
) (
    input  logic [p_NUM_REQ-1:0] req,
    input  logic [p_PTR_W-1:0]   ptr,
    output logic [p_NUM_REQ-1:0] pick,
    output logic                 valid
);

    int                 idx;
    logic [p_PTR_W-1:0] idx_p;

    always_comb begin
        pick  = '0;
        valid = 1'b0;
        idx   = 0;
        idx_p = '0;
        for (int i = 0; i < p_NUM_REQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= p_NUM_REQ) begin
                idx = idx - p_NUM_REQ;
            end
            idx_p = p_PTR_W'(idx);
            if (!valid && req[idx_p]) begin
                pick[idx_p] = 1'b1;
                valid       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_enq_arbiter.sv
// rtl/fifo_enq_arbiter.sv - round-robin, burst-bounded sharing of one fifo enqueue port
import fifo_arb_pkg::*;

module fifo_enq_arbiter #(
    parameter int p_WORD_LEN  = 8,
    parameter int p_NUM_REQ   = 4,
    parameter int p_MAX_BURST = 4
) (
    input  logic                            i_clk,
    input  logic                            i_reset,
    input  logic [p_NUM_REQ*p_WORD_LEN-1:0] req_data,
    input  logic [p_NUM_REQ-1:0]            req_en,
    output logic [p_NUM_REQ-1:0]            req_rdy,
    output logic [p_WORD_LEN-1:0]           fifo_enq_data,
    output logic                            fifo_enq_en,
    input  logic                            fifo_enq_rdy,
    output logic [p_NUM_REQ-1:0]            o_grant,
    output logic                            o_busy
);

    localparam int                PTR_W    = $clog2(p_NUM_REQ);
    localparam int                CNT_W    = cnt_width(p_MAX_BURST);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(p_MAX_BURST - 1);
    localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(p_NUM_REQ - 1);

    arb_state_t             state;
    arb_state_t             state_nxt;
    logic [PTR_W-1:0]       r_ptr;
    logic [PTR_W-1:0]       ptr_nxt;
    logic [p_NUM_REQ-1:0]   r_grant;
    logic [p_NUM_REQ-1:0]   grant_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       cnt_nxt;

    logic [p_NUM_REQ-1:0]   pick;
    logic                   pick_vld;
    logic [PTR_W-1:0]       g_idx;
    logic [p_WORD_LEN-1:0]  g_data;
    logic                   g_req;
    logic                   active;
    logic                   xfer;

    rr_pick #(
        .p_NUM_REQ (p_NUM_REQ),
        .p_PTR_W   (PTR_W)
    ) u_pick (
        .req   (req_en),
        .ptr   (r_ptr),
        .pick  (pick),
        .valid (pick_vld)
    );

    always_comb begin
        g_idx  = '0;
        g_data = '0;
        for (int i = 0; i < p_NUM_REQ; i++) begin
            if (r_grant[i]) begin
                g_idx  = PTR_W'(i);
                g_data = req_data[i*p_WORD_LEN +: p_WORD_LEN];
            end
        end
    end

    // Reset is gated into the datapath so an in-flight word is never pushed during reset.
    assign active = (state == ST_GRANT) && !i_reset;
    assign g_req  = |(req_en & r_grant);
    assign xfer   = active && g_req && fifo_enq_rdy;

    always_comb begin
        req_rdy       = (active && fifo_enq_rdy) ? r_grant : '0;
        fifo_enq_en   = xfer;
        fifo_enq_data = active ? g_data : '0;
        o_grant       = i_reset ? '0 : r_grant;
        o_busy        = active;
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = r_ptr;
        grant_nxt = r_grant;
        cnt_nxt   = r_cnt;
        case (state)
            ST_IDLE: begin
                if (pick_vld) begin
                    grant_nxt = pick;
                    cnt_nxt   = '0;
                    state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (xfer) begin
                    cnt_nxt = r_cnt + 1'b1;
                end
                // A full fifo only stalls the grant; release needs burst end or a dropped request.
                if ((xfer && (r_cnt == CNT_LAST)) || !g_req) begin
                    state_nxt = ST_IDLE;
                    grant_nxt = '0;
                    ptr_nxt   = (g_idx == PTR_LAST) ? '0 : g_idx + 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state   <= ST_IDLE;
            r_ptr   <= '0;
            r_grant <= '0;
            r_cnt   <= '0;
        end else begin
            state   <= state_nxt;
            r_ptr   <= ptr_nxt;
            r_grant <= grant_nxt;
            r_cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            assert (!(fifo_enq_en && !fifo_enq_rdy));
            assert ($onehot0(o_grant));
        end
    end

endmodule

// File: tb/tb_fifo_enq_arbiter.sv
// tb/tb_fifo_enq_arbiter.sv - scoreboard bench for fifo_enq_arbiter
module tb_fifo_enq_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           i_clk = 1'b0;
    logic           i_reset;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_en;
    logic [N-1:0]   req_rdy;
    logic [W-1:0]   fifo_enq_data;
    logic           fifo_enq_en;
    logic           fifo_enq_rdy;
    logic [N-1:0]   o_grant;
    logic           o_busy;

    logic [N*W-1:0] req_data1;
    logic [N-1:0]   req_en1;
    logic [N-1:0]   req_rdy1;
    logic [W-1:0]   fifo_enq_data1;
    logic           fifo_enq_en1;
    logic           fifo_enq_rdy1;
    logic [N-1:0]   o_grant1;
    logic           o_busy1;

    typedef struct {
        int         prod;
        logic [7:0] data;
    } exp_t;

    exp_t         sb[$];
    logic [7:0]   pq[N][$];
    logic [N-1:0] acc;
    int           checks;
    int           failures;
    int           enq_count;
    logic         reset_next;
    logic         rdy_next;
    logic         all1_next;

    always #5 i_clk = ~i_clk;

    fifo_enq_arbiter #(.p_WORD_LEN(W), .p_NUM_REQ(N), .p_MAX_BURST(4)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .req_data(req_data), .req_en(req_en),
        .req_rdy(req_rdy), .fifo_enq_data(fifo_enq_data), .fifo_enq_en(fifo_enq_en),
        .fifo_enq_rdy(fifo_enq_rdy), .o_grant(o_grant), .o_busy(o_busy)
    );

    fifo_enq_arbiter #(.p_WORD_LEN(W), .p_NUM_REQ(N), .p_MAX_BURST(1)) dut1 (
        .i_clk(i_clk), .i_reset(i_reset), .req_data(req_data1), .req_en(req_en1),
        .req_rdy(req_rdy1), .fifo_enq_data(fifo_enq_data1), .fifo_enq_en(fifo_enq_en1),
        .fifo_enq_rdy(fifo_enq_rdy1), .o_grant(o_grant1), .o_busy(o_busy1)
    );

    // Scoreboard: every pushed word must match the next expected word and its producer's grant.
    always @(negedge i_clk) begin
        exp_t         e;
        logic [N-1:0] eg;
        if (fifo_enq_en === 1'b1) begin
            enq_count++;
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected_push data=%h grant=%b", fifo_enq_data, o_grant);
            end else begin
                e = sb.pop_front();
                eg = '0;
                eg[e.prod] = 1'b1;
                if (fifo_enq_data !== e.data || o_grant !== eg) begin
                    failures++;
                    $display("FAIL sb_word got data=%h grant=%b exp data=%h grant=%b",
                             fifo_enq_data, o_grant, e.data, eg);
                end
            end
        end
    end

    function automatic logic [7:0] word(input int k, input int j);
        return 8'(k * 16 + j);
    endfunction

    task automatic load_prod(input int k, input int first, input int n);
        for (int j = first; j < first + n; j++) pq[k].push_back(word(k, j));
    endtask

    task automatic expect_words(input int k, input int first, input int n);
        exp_t e;
        for (int j = first; j < first + n; j++) begin
            e.prod = k;
            e.data = word(k, j);
            sb.push_back(e);
        end
    endtask

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            req_en[k] = (pq[k].size() != 0);
            req_data[k*W +: W] = (pq[k].size() != 0) ? pq[k][0] : 8'h00;
        end
        fifo_enq_rdy = rdy_next;
        i_reset      = reset_next;
        req_en1      = all1_next ? '1 : '0;
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
        for (int k = 0; k < N; k++) begin
            if (acc[k] && pq[k].size() != 0) void'(pq[k].pop_front());
        end
        drive();
        @(negedge i_clk);
        acc = req_en & req_rdy;
    endtask

    task automatic clear_prods();
        for (int k = 0; k < N; k++) pq[k].delete();
    endtask

    task automatic do_reset();
        clear_prods();
        sb.delete();
        rdy_next   = 1'b1;
        all1_next  = 1'b0;
        reset_next = 1'b1;
        tick();
        tick();
        reset_next = 1'b0;
        tick();
    endtask

    task automatic check_sb_empty(input string name);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL %s words_left=%0d exp=0", name, sb.size());
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (req_rdy !== 4'b0 || fifo_enq_en !== 1'b0 || fifo_enq_data !== 8'h00 ||
            o_grant !== 4'b0 || o_busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs got rdy=%b en=%b data=%h grant=%b busy=%b exp all 0",
                     req_rdy, fifo_enq_en, fifo_enq_data, o_grant, o_busy);
        end
        checks++;
        if (dut.r_ptr !== 2'd0 || dut.r_cnt !== 3'd0) begin
            failures++;
            $display("FAIL reset_state got ptr=%0d cnt=%0d exp 0 0", dut.r_ptr, dut.r_cnt);
        end
    endtask

    task automatic test_single();
        do_reset();
        load_prod(1, 0, 6);
        expect_words(1, 0, 6);
        tick();
        checks++;
        if (o_busy !== 1'b0 || fifo_enq_en !== 1'b0) begin
            failures++;
            $display("FAIL t1_c0_idle got busy=%b en=%b exp 0 0", o_busy, fifo_enq_en);
        end
        tick();
        checks++;
        if (o_grant !== 4'b0010) begin
            failures++;
            $display("FAIL t1_c1_grant got=%b exp=0010", o_grant);
        end
        repeat (4) tick();
        checks++;
        if (o_grant !== 4'b0000 || o_busy !== 1'b0) begin
            failures++;
            $display("FAIL t1_c5_bubble got grant=%b busy=%b exp 0000 0", o_grant, o_busy);
        end
        tick();
        checks++;
        if (o_grant !== 4'b0010) begin
            failures++;
            $display("FAIL t1_c6_regrant got=%b exp=0010", o_grant);
        end
        repeat (2) tick();
        checks++;
        if (o_grant !== 4'b0010 || fifo_enq_en !== 1'b0) begin
            failures++;
            $display("FAIL t1_c8_drop got grant=%b en=%b exp 0010 0", o_grant, fifo_enq_en);
        end
        tick();
        checks++;
        if (o_grant !== 4'b0000) begin
            failures++;
            $display("FAIL t1_c9_release got=%b exp=0000", o_grant);
        end
        check_sb_empty("t1_sb_empty");
    endtask

    task automatic test_all_requesting();
        logic [N-1:0] eg;
        do_reset();
        for (int k = 0; k < N; k++) load_prod(k, 0, 8);
        for (int k = 0; k < N; k++) expect_words(k, 0, 4);
        expect_words(0, 4, 1);
        enq_count = 0;
        tick();
        for (int c = 1; c <= 21; c++) begin
            tick();
            if (c % 5 == 1) begin
                eg = '0;
                eg[((c - 1) / 5) % N] = 1'b1;
                checks++;
                if (o_grant !== eg) begin
                    failures++;
                    $display("FAIL t2_grant_c%0d got=%b exp=%b", c, o_grant, eg);
                end
            end
            if (c == 20) begin
                checks++;
                if (enq_count != 16) begin
                    failures++;
                    $display("FAIL t2_words_in_20 got=%0d exp=16", enq_count);
                end
            end
        end
        clear_prods();
        tick();
        check_sb_empty("t2_sb_empty");
    endtask

    task automatic test_backpressure();
        do_reset();
        load_prod(0, 0, 6);
        load_prod(1, 0, 2);
        expect_words(0, 0, 4);
        expect_words(1, 0, 2);
        expect_words(0, 4, 2);
        repeat (3) tick();
        rdy_next = 1'b0;
        for (int c = 3; c <= 5; c++) begin
            tick();
            checks++;
            if (req_rdy !== 4'b0 || fifo_enq_en !== 1'b0 || o_grant !== 4'b0001) begin
                failures++;
                $display("FAIL t3_stall_c%0d got rdy=%b en=%b grant=%b exp 0000 0 0001",
                         c, req_rdy, fifo_enq_en, o_grant);
            end
        end
        rdy_next = 1'b1;
        repeat (3) tick();
        checks++;
        if (o_grant !== 4'b0000) begin
            failures++;
            $display("FAIL t3_c8_rotate got=%b exp=0000", o_grant);
        end
        tick();
        checks++;
        if (o_grant !== 4'b0010) begin
            failures++;
            $display("FAIL t3_c9_next got=%b exp=0010", o_grant);
        end
        repeat (7) tick();
        check_sb_empty("t3_sb_empty");
    endtask

    task automatic test_early_drop();
        do_reset();
        load_prod(2, 0, 2);
        load_prod(3, 0, 4);
        expect_words(2, 0, 2);
        expect_words(3, 0, 4);
        repeat (2) tick();
        checks++;
        if (o_grant !== 4'b0100) begin
            failures++;
            $display("FAIL t4_c1_grant got=%b exp=0100", o_grant);
        end
        repeat (3) tick();
        checks++;
        if (o_grant !== 4'b0000 || dut.r_ptr !== 2'd3) begin
            failures++;
            $display("FAIL t4_c4_release got grant=%b ptr=%0d exp 0000 3", o_grant, dut.r_ptr);
        end
        tick();
        checks++;
        if (o_grant !== 4'b1000) begin
            failures++;
            $display("FAIL t4_c5_grant got=%b exp=1000", o_grant);
        end
        repeat (5) tick();
        check_sb_empty("t4_sb_empty");
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        load_prod(1, 0, 3);
        expect_words(1, 0, 2);
        repeat (3) tick();
        reset_next = 1'b1;
        tick();
        checks++;
        if (fifo_enq_en !== 1'b0 || req_rdy !== 4'b0) begin
            failures++;
            $display("FAIL t5_inflight got en=%b rdy=%b exp 0 0000", fifo_enq_en, req_rdy);
        end
        reset_next = 1'b0;
        clear_prods();
        load_prod(2, 0, 1);
        load_prod(3, 0, 1);
        expect_words(2, 0, 1);
        expect_words(3, 0, 1);
        tick();
        checks++;
        if (req_rdy !== 4'b0 || fifo_enq_en !== 1'b0 || fifo_enq_data !== 8'h00 ||
            o_grant !== 4'b0 || o_busy !== 1'b0 || dut.r_ptr !== 2'd0) begin
            failures++;
            $display("FAIL t5_after_reset got rdy=%b en=%b data=%h grant=%b busy=%b ptr=%0d exp all 0",
                     req_rdy, fifo_enq_en, fifo_enq_data, o_grant, o_busy, dut.r_ptr);
        end
        tick();
        checks++;
        if (o_grant !== 4'b0100) begin
            failures++;
            $display("FAIL t5_next_grant got=%b exp=0100", o_grant);
        end
        repeat (5) tick();
        check_sb_empty("t5_sb_empty");
    endtask

    task automatic test_burst_one();
        logic [N-1:0] eg;
        do_reset();
        all1_next = 1'b1;
        tick();
        for (int c = 1; c <= 8; c++) begin
            tick();
            eg = '0;
            if (c % 2 == 1) eg[((c - 1) / 2) % N] = 1'b1;
            checks++;
            if (fifo_enq_en1 !== (c % 2 == 1) || o_grant1 !== eg ||
                (c % 2 == 1 && fifo_enq_data1 !== 8'(8'hA0 + ((c - 1) / 2)))) begin
                failures++;
                $display("FAIL t6_c%0d got en=%b grant=%b data=%h exp en=%0d grant=%b",
                         c, fifo_enq_en1, o_grant1, fifo_enq_data1, c % 2, eg);
            end
        end
        all1_next = 1'b0;
        tick();
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        enq_count     = 0;
        acc           = '0;
        reset_next    = 1'b1;
        rdy_next      = 1'b1;
        all1_next     = 1'b0;
        fifo_enq_rdy1 = 1'b1;
        req_data1     = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        drive();
        test_reset();
        test_single();
        test_all_requesting();
        test_backpressure();
        test_early_drop();
        test_reset_mid_burst();
        test_burst_one();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
